// File: rtl/cam_config.sv
// -----------------------------------------------------------------------------
// cam_config
//
// Walks the OV7670 register ROM from address 0 and hands each entry to the
// SCCB master as one register write.
//
// ROM entry format: [15:8] register address, [7:0] register data.
//   16'hFFFF  end marker: the run finishes.
//   16'hFFF0  delay marker: a settle wait is inserted.
//   other     written as-is. This includes address 0xFF with any data
//             other than F0/FF.
//
// If no end marker is found, the run stops after entry 255 has been
// processed. The ROM address never wraps.
//
// Build option:
//   CAM_CONFIG_DELAY_EN  When defined, a delay marker waits DLY_CYC clocks,
//                        where DLY_CYC = (CLK_F/1000)*DELAY_MS.
//                        When undefined, a delay marker is skipped with no
//                        wait and no write. This keeps simulation fast.
//
// Parameters:
//   CLK_F     i_Clk frequency in Hz
//   DELAY_MS  settle time in ms for a delay entry
//
// Ports:
//   i_Clk         system clock
//   i_Rst         synchronous, active-low reset
//   i_Start       level; starts a run when sampled high in IDLE or DONE
//   o_Rom_Addr    ROM address
//   i_Rom_Data    ROM entry; valid one cycle after the ROM samples the address
//   o_SCCB_Start  one-cycle write request to the SCCB master
//   o_SCCB_Addr   register address; held until the master is ready again
//   o_SCCB_Data   register data; held until the master is ready again
//   i_SCCB_Ready  master idle; drops after a request, rises when the write is done
//   o_Busy        high in every state except IDLE and DONE
//   o_Done        high in DONE
// -----------------------------------------------------------------------------
module cam_config #(
    parameter int CLK_F    = 25_000_000,
    parameter int DELAY_MS = 10
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    output logic [7:0]  o_Rom_Addr,
    input  logic [15:0] i_Rom_Data,
    output logic        o_SCCB_Start,
    output logic [7:0]  o_SCCB_Addr,
    output logic [7:0]  o_SCCB_Data,
    input  logic        i_SCCB_Ready,
    output logic        o_Busy,
    output logic        o_Done
);

    localparam int DLY_CYC = (CLK_F / 1000) * DELAY_MS;
    localparam int CNT_W   = (DLY_CYC > 0) ? $clog2(DLY_CYC + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef CAM_CONFIG_DELAY_EN
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DLY_CYC);
`endif

    localparam logic [15:0] END_MARK = 16'hFFFF;
    localparam logic [15:0] DLY_MARK = 16'hFFF0;
    localparam logic [7:0]  LAST_ADDR = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_ROM_WAIT = 4'd2,
        ST_DECODE   = 4'd3,
        ST_TX_REQ   = 4'd4,
        ST_TX_GAP   = 4'd5,
        ST_TX_WAIT  = 4'd6,
        ST_DELAY    = 4'd7,
        ST_NEXT     = 4'd8,
        ST_DONE     = 4'd9
    } state_t;

    state_t           state_q,      state_d;
    logic [7:0]       rom_addr_q,   rom_addr_d;
    logic [7:0]       sccb_addr_q,  sccb_addr_d;
    logic [7:0]       sccb_data_q,  sccb_data_d;
    logic             sccb_start_q, sccb_start_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
    logic [CNT_W-1:0] dly_cnt_q,    dly_cnt_d;

    // Compute the next state, the datapath updates and the registered output values.
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        sccb_addr_d  = sccb_addr_q;
        sccb_data_d  = sccb_data_q;
        sccb_start_d = 1'b0;
        dly_cnt_d    = dly_cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_Start) begin
                    rom_addr_d = 8'h00;
                    state_d    = ST_FETCH;
                end else begin
                    state_d    = state_q;
                end
            end

            // FETCH and ROM_WAIT cover the registered ROM read latency.
            ST_FETCH: begin
                state_d = ST_ROM_WAIT;
            end

            ST_ROM_WAIT: begin
                state_d = ST_DECODE;
            end

            ST_DECODE: begin
                if (i_Rom_Data == END_MARK) begin
                    state_d = ST_DONE;
                end else if (i_Rom_Data == DLY_MARK) begin
`ifdef CAM_CONFIG_DELAY_EN
                    dly_cnt_d = CNT_LOAD;
                    state_d   = ST_DELAY;
`else
                    state_d   = ST_NEXT;
`endif
                end else begin
                    sccb_addr_d = i_Rom_Data[15:8];
                    sccb_data_d = i_Rom_Data[7:0];
                    state_d     = ST_TX_REQ;
                end
            end

            // The request is raised only when the master reports idle.
            ST_TX_REQ: begin
                if (i_SCCB_Ready) begin
                    sccb_start_d = 1'b1;
                    state_d      = ST_TX_GAP;
                end else begin
                    state_d      = ST_TX_REQ;
                end
            end

            // Ready may still read high for one cycle after the request.
            // It is ignored here so a stale "idle" is not taken as completion.
            ST_TX_GAP: begin
                state_d = ST_TX_WAIT;
            end

            ST_TX_WAIT: begin
                if (i_SCCB_Ready) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end

            // The counter is loaded with DLY_CYC and leaves on the cycle it holds 1.
            // This gives exactly DLY_CYC cycles in this state.
            ST_DELAY: begin
                if (dly_cnt_q <= CNT_ONE) begin
                    dly_cnt_d = CNT_ZERO;
                    state_d   = ST_NEXT;
                end else begin
                    dly_cnt_d = dly_cnt_q - CNT_ONE;
                    state_d   = ST_DELAY;
                end
            end

            // Stop after the last ROM entry instead of wrapping to address 0.
            ST_NEXT: begin
                if (rom_addr_q == LAST_ADDR) begin
                    state_d    = ST_DONE;
                end else begin
                    rom_addr_d = rom_addr_q + 8'd1;
                    state_d    = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
            busy_d = 1'b0;
        end else begin
            busy_d = 1'b1;
        end
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state_q      <= ST_IDLE;
            rom_addr_q   <= 8'h00;
            sccb_addr_q  <= 8'h00;
            sccb_data_q  <= 8'h00;
            sccb_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dly_cnt_q    <= CNT_ZERO;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            sccb_addr_q  <= sccb_addr_d;
            sccb_data_q  <= sccb_data_d;
            sccb_start_q <= sccb_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dly_cnt_q    <= dly_cnt_d;
        end
    end

    assign o_Rom_Addr   = rom_addr_q;
    assign o_SCCB_Addr  = sccb_addr_q;
    assign o_SCCB_Data  = sccb_data_q;
    assign o_SCCB_Start = sccb_start_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;

endmodule

// File: tb/tb_cam_config.sv
module tb_cam_config;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_start;
    logic [7:0]  sccb_addr;
    logic [7:0]  sccb_data;
    logic        sccb_ready;
    logic        busy;
    logic        done;

`ifdef CAM_CONFIG_DELAY_EN
    localparam bit DLY_EN = 1'b1;
`else
    localparam bit DLY_EN = 1'b0;
`endif
    localparam int DLY_CYC  = 10;
    localparam int DLY_COST = DLY_EN ? DLY_CYC : 0;

    cam_config #(.CLK_F(1000), .DELAY_MS(10)) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Start      (start),
        .o_Rom_Addr   (rom_addr),
        .i_Rom_Data   (rom_data),
        .o_SCCB_Start (sccb_start),
        .o_SCCB_Addr  (sccb_addr),
        .o_SCCB_Data  (sccb_data),
        .i_SCCB_Ready (sccb_ready),
        .o_Busy       (busy),
        .o_Done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] rom_mem [256];
    int          hold_h   = 2;
    bit          mst_busy = 1'b0;
    int          mst_cnt  = 0;
    bit          mst_clr  = 1'b0;
    logic [15:0] cap_q [$];
    int          cap_cyc [$];
    int          cyc      = 0;
    int          busy_cnt = 0;
    logic        prev_start = 1'b0;
    logic        prev_busy  = 1'b0;
    logic [7:0]  prev_addr  = 8'h00;
    logic [15:0] last_w;

    logic [15:0] exp_q [$];
    int          exp_busy;
    int          exp_addr;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle checks, write capture, SCCB master and ROM models.
    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (rst) begin
            check("start_consecutive", int'(prev_start && sccb_start), 0);
            check("busy_done_exclusive", int'(busy && done), 0);
            if (sccb_start) check("start_needs_ready", int'(sccb_ready), 1);
            if (mst_busy && !mst_clr) begin
                last_w = cap_q[$];
                check("sccb_addr_stable", int'(sccb_addr), int'(last_w[15:8]));
                check("sccb_data_stable", int'(sccb_data), int'(last_w[7:0]));
            end
            if (prev_busy && busy && prev_addr == 8'hFF)
                check("rom_addr_no_wrap", int'(rom_addr), 255);
            if (sccb_start) begin
                cap_q.push_back({sccb_addr, sccb_data});
                cap_cyc.push_back(cyc);
            end
        end
        if (mst_clr) begin
            mst_busy   = 1'b0;
            sccb_ready = 1'b1;
        end else if (sccb_start) begin
            mst_busy   = 1'b1;
            mst_cnt    = hold_h;
            sccb_ready = 1'b0;
        end else if (mst_busy) begin
            mst_cnt--;
            if (mst_cnt == 0) begin
                mst_busy   = 1'b0;
                sccb_ready = 1'b1;
            end
        end
        rom_data   = rom_mem[rom_addr];
        prev_start = sccb_start;
        prev_busy  = busy;
        prev_addr  = rom_addr;
    end

    task automatic build_model(input int h);
        exp_q.delete();
        exp_busy = 0;
        exp_addr = 255;
        for (int a = 0; a < 256; a++) begin
            if (rom_mem[a] == 16'hFFFF) begin
                exp_busy += 3;
                exp_addr = a;
                break;
            end else if (rom_mem[a] == 16'hFFF0) begin
                exp_busy += 4 + DLY_COST;
            end else begin
                exp_busy += 6 + h;
                exp_q.push_back(rom_mem[a]);
            end
        end
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int a = 0; a < 256; a++) rom_mem[a] = v;
    endtask

    task automatic load_rom_a();
        fill_rom(16'hFFFF);
        rom_mem[0] = 16'h1280;
        rom_mem[1] = 16'hFFF0;
        rom_mem[2] = 16'h1204;
        rom_mem[3] = 16'hFFFF;
    endtask

    task automatic run_cfg(input string name, input int h, input int lit_busy);
        int n;
        build_model(h);
        hold_h = h;
        @(negedge clk);
        cap_q.delete();
        cap_cyc.delete();
        busy_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_done_falls"}, int'(done), 0);
        check({name, "_busy_rises"}, int'(busy), 1);
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reached_done"}, int'(done), 1);
        check({name, "_busy_cycles"}, busy_cnt, exp_busy);
        if (lit_busy >= 0) check({name, "_busy_cycles_literal"}, busy_cnt, lit_busy);
        check({name, "_write_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < cap_q.size())
                check($sformatf("%s_write%0d", name, i), int'(cap_q[i]), int'(exp_q[i]));
        end
        check({name, "_final_rom_addr"}, int'(rom_addr), exp_addr);
    endtask

    initial begin
        int n0;
        int n;
        rst        = 1'b0;
        start      = 1'b0;
        sccb_ready = 1'b1;
        rom_data   = 16'h0000;
        load_rom_a();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_sccb_start", int'(sccb_start), 0);
        check("reset_sccb_addr", int'(sccb_addr), 0);
        check("reset_sccb_data", int'(sccb_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // delay ROM: (12,80) then (12,04)
        run_cfg("delay_rom", 2, DLY_EN ? 33 : 23);
        check("delay_rom_write0_literal", int'(cap_q.size() > 0 ? cap_q[0] : 16'h0000), 16'h1280);
        check("delay_rom_write1_literal", int'(cap_q.size() > 1 ? cap_q[1] : 16'h0000), 16'h1204);
        check("delay_rom_addr_literal", int'(rom_addr), 3);
        if (cap_cyc.size() > 1)
            check("delay_rom_pulse_gap", cap_cyc[1] - cap_cyc[0], DLY_EN ? 22 : 12);
        else
            check("delay_rom_pulse_gap", 0, DLY_EN ? 22 : 12);

        // restart from DONE replays the same sequence
        repeat (3) @(negedge clk);
        check("done_holds", int'(done), 1);
        run_cfg("restart", 2, DLY_EN ? 33 : 23);

        // long handshake
        fill_rom(16'hFFFF);
        rom_mem[0] = 16'h1100;
        run_cfg("handshake", 20, 29);
        check("handshake_addr_literal", int'(rom_addr), 1);

        // address 0xFF with ordinary data is written
        fill_rom(16'hFFFF);
        rom_mem[0] = 16'hFF12;
        rom_mem[1] = 16'h3456;
        run_cfg("ff_addr", 1, 17);

        // reset in the middle of a run
        load_rom_a();
        hold_h = 2;
        @(negedge clk);
        cap_q.delete();
        cap_cyc.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cap_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midreset_first_pulse_seen", int'(cap_q.size() > 0), 1);
        repeat (10) @(negedge clk);
        rst     = 1'b0;
        mst_clr = 1'b1;
        @(negedge clk);
        check("midreset_rom_addr", int'(rom_addr), 0);
        check("midreset_sccb_start", int'(sccb_start), 0);
        check("midreset_sccb_addr", int'(sccb_addr), 0);
        check("midreset_sccb_data", int'(sccb_data), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        rst = 1'b1;
        @(negedge clk);
        mst_clr = 1'b0;
        n0 = cap_q.size();
        repeat (30) @(negedge clk);
        check("midreset_no_pulses", cap_q.size(), n0);
        check("midreset_stays_idle", int'(busy), 0);
        check("midreset_no_done", int'(done), 0);

        // no end marker: 256 writes, stop at 0xFF
        fill_rom(16'h0001);
        run_cfg("no_end", 1, 1792);
        check("no_end_write_count_literal", cap_q.size(), 256);
        check("no_end_addr_literal", int'(rom_addr), 255);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
